// File: rtl/wave_weight_sequencer.sv
// wave_weight_sequencer
// Producer side of the bit-serial Wave MAC interface. Captures a vector of
// signed weights, converts each to sign-magnitude and presents the magnitude
// bit-planes one column per cycle, MSB first, together with the MAC pipeline
// controls (en, load_accum, vec_done). All outputs are registered.
//
// Optional build macro: WAVE_ZERO_COL_SKIP_EN
//   When defined, magnitude columns that are zero in every lane are not issued.
//   An all-zero vector still issues a single column 0.
//
// state | meaning
// IDLE  | no vector in flight, w_ready=1, en=0
// ISSUE | presenting column col_q of the captured vector, en=1
// DRAIN | one zero column so the MAC psum register can settle, en=1, w_ready=1
module wave_weight_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int IN_REG     = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic signed [DATA_WIDTH-1:0]    w_in [VEC_LENGTH],
    output logic [VEC_LENGTH-1:0]           sign,
    output logic [VEC_LENGTH-1:0]           w_bit,
    output logic [$clog2(DATA_WIDTH-1)-1:0] column_idx,
    output logic                            en,
    output logic                            load_accum,
    output logic                            vec_done
);
    localparam int MW = DATA_WIDTH - 1;
    localparam int CW = $clog2(MW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [VEC_LENGTH-1:0] sgn_q, sgn_d;
    logic [MW-1:0]         mag_q [VEC_LENGTH];
    logic [MW-1:0]         mag_d [VEC_LENGTH];
    logic [MW-1:0]         cmask_q, cmask_d;

    logic                  w_ready_q, w_ready_d;
    logic                  en_q, en_d;
    logic [VEC_LENGTH-1:0] sign_q, sign_d;
    logic [VEC_LENGTH-1:0] w_bit_q, w_bit_d;
    logic [CW-1:0]         column_idx_q, column_idx_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  load_accum_q, load_accum_d;
    logic                  done_p1_q, done_p1_d;
    logic                  vec_done_q, vec_done_d;

    logic [VEC_LENGTH-1:0] in_sgn;
    logic [MW-1:0]         in_mag [VEC_LENGTH];
    logic [MW-1:0]         in_mask;
    logic                  accept;
    logic                  load;

    // Highest set column strictly below lim (0 when none).
    function automatic logic [CW-1:0] top_below(input logic [MW-1:0] mask, input int lim);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < MW; i++) begin
            if (mask[i] && (i < lim)) r = CW'(i);
        end
        return r;
    endfunction

    // True when some column strictly below lim is still to be issued.
    function automatic logic any_below(input logic [MW-1:0] mask, input int lim);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MW; i++) begin
            if (mask[i] && (i < lim)) r = 1'b1;
        end
        return r;
    endfunction

    // Sign-magnitude conversion of the incoming vector; most-negative saturates.
    always_comb begin
        in_mask = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            in_sgn[j] = w_in[j][DATA_WIDTH-1];
            if (in_sgn[j] && (w_in[j][MW-1:0] == '0)) begin
                in_mag[j] = '1;
            end else if (in_sgn[j]) begin
                in_mag[j] = ~w_in[j][MW-1:0] + 1'b1;
            end else begin
                in_mag[j] = w_in[j][MW-1:0];
            end
`ifdef WAVE_ZERO_COL_SKIP_EN
            in_mask = in_mask | in_mag[j];
`endif
        end
`ifndef WAVE_ZERO_COL_SKIP_EN
        in_mask = '1;
`endif
    end

    // Next-state logic plus the registered output values for the next cycle.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        sgn_d   = sgn_q;
        mag_d   = mag_q;
        cmask_d = cmask_q;
        accept  = w_valid && w_ready_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            ISSUE: begin
                if (any_below(cmask_q, int'(col_q))) begin
                    col_d = top_below(cmask_q, int'(col_q));
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) load = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = ISSUE;
            sgn_d   = in_sgn;
            mag_d   = in_mag;
            cmask_d = in_mask;
            col_d   = top_below(in_mask, MW);
        end

        last_d       = (state_d == ISSUE) && !any_below(cmask_d, int'(col_d));
        w_ready_d    = (state_d != ISSUE) || last_d;
        en_d         = (state_d != IDLE);
        column_idx_d = (state_d == ISSUE) ? col_d : '0;
        sign_d       = (state_d == ISSUE) ? sgn_d : '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            w_bit_d[j] = (state_d == ISSUE) ? mag_d[j][col_d] : 1'b0;
        end
        first_d      = load;
        load_accum_d = first_q;
        done_p1_d    = last_q;
        vec_done_d   = done_p1_q;
    end

    // State, captured vector and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            sgn_q        <= '0;
            mag_q        <= '{default: '0};
            cmask_q      <= '0;
            w_ready_q    <= 1'b0;
            en_q         <= 1'b0;
            sign_q       <= '0;
            w_bit_q      <= '0;
            column_idx_q <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            load_accum_q <= 1'b0;
            done_p1_q    <= 1'b0;
            vec_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            sgn_q        <= sgn_d;
            mag_q        <= mag_d;
            cmask_q      <= cmask_d;
            w_ready_q    <= w_ready_d;
            en_q         <= en_d;
            sign_q       <= sign_d;
            w_bit_q      <= w_bit_d;
            column_idx_q <= column_idx_d;
            first_q      <= first_d;
            last_q       <= last_d;
            load_accum_q <= load_accum_d;
            done_p1_q    <= done_p1_d;
            vec_done_q   <= vec_done_d;
        end
    end

    assign w_ready    = w_ready_q;
    assign sign       = sign_q;
    assign w_bit      = w_bit_q;
    assign column_idx = column_idx_q;

    generate
        if (IN_REG != 0) begin : g_in_reg
            // The MAC registers its data inputs, so its controls lag one more cycle.
            logic en_dly_q, en_dly_d;
            logic la_dly_q, la_dly_d;
            logic vd_dly_q, vd_dly_d;

            // Control delay line inputs.
            always_comb begin
                en_dly_d = en_q;
                la_dly_d = load_accum_q;
                vd_dly_d = vec_done_q;
            end

            // Control delay line registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    en_dly_q <= 1'b0;
                    la_dly_q <= 1'b0;
                    vd_dly_q <= 1'b0;
                end else begin
                    en_dly_q <= en_dly_d;
                    la_dly_q <= la_dly_d;
                    vd_dly_q <= vd_dly_d;
                end
            end

            assign en         = en_dly_q;
            assign load_accum = la_dly_q;
            assign vec_done   = vd_dly_q;
        end else begin : g_direct
            assign en         = en_q;
            assign load_accum = load_accum_q;
            assign vec_done   = vec_done_q;
        end
    endgenerate

endmodule
